// File: rtl/coin_input_encoder.sv
// Coin button front end: per-button debounce, press-edge detect, priority encode and one-shot issue FSM.
// Define COIN_ENC_SYNC_EN to put a 2-flop synchronizer ahead of each debouncer (adds 2 cycles of latency).
module coin_input_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [1:0] EO,
  output logic       coin_valid,
  output logic       ret_pulse,
  output logic       busy,
  output logic       multi_err
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_LOCKOUT = 2'b10
  } state_t;

  logic [3:0] sample;

`ifdef COIN_ENC_SYNC_EN
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = btn;
`endif

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       level_q, level_d;
  logic [3:0]       prev_q, prev_d;

  // Counter only advances while the sample disagrees with the accepted level,
  // and the compare is >= so it can never run past the terminal value.
  always_comb begin
    level_d = level_q;
    prev_d  = level_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sample[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_LAST) begin
        level_d[i] = sample[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      level_q <= level_d;
      prev_q  <= prev_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic [3:0] press;
  assign press = level_q & ~prev_q;

  state_t     state_q, state_d;
  logic [1:0] eo_q, eo_d;
  logic       cv_q, cv_d;
  logic       ret_q, ret_d;
  logic       merr_q, merr_d;

  always_comb begin
    state_d = state_q;
    eo_d    = 2'b00;
    cv_d    = 1'b0;
    ret_d   = 1'b0;
    merr_d  = merr_q;
    case (state_q)
      S_IDLE: begin
        if (|press) begin
          state_d = S_ISSUE;
          if (press[2]) begin
            eo_d = 2'b11;
            cv_d = 1'b1;
          end else if (press[1]) begin
            eo_d = 2'b10;
            cv_d = 1'b1;
          end else if (press[0]) begin
            eo_d = 2'b01;
            cv_d = 1'b1;
          end else begin
            ret_d = 1'b1;
          end
          if ($countones(press) > 1) merr_d = 1'b1;
        end
      end
      S_ISSUE:   state_d = S_LOCKOUT;
      S_LOCKOUT: if (level_q == 4'b0000) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      eo_q    <= 2'b00;
      cv_q    <= 1'b0;
      ret_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      eo_q    <= eo_d;
      cv_q    <= cv_d;
      ret_q   <= ret_d;
      merr_q  <= merr_d;
    end
  end

  assign EO         = eo_q;
  assign coin_valid = cv_q;
  assign ret_pulse  = ret_q;
  assign busy       = (state_q != S_IDLE);
  assign multi_err  = merr_q;

endmodule

// File: tb/tb_coin_input_encoder.sv
// Scoreboard bench for coin_input_encoder: directed presses push expected strobes,
// a negedge monitor pops and checks them, including strobe timing in clock edges.
module tb_coin_input_encoder;

  localparam int D = 4;
`ifdef COIN_ENC_SYNC_EN
  localparam int LAT = D + 2;
`else
  localparam int LAT = D;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic [1:0] EO;
  logic       coin_valid;
  logic       ret_pulse;
  logic       busy;
  logic       multi_err;

  coin_input_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .EO         (EO),
    .coin_valid (coin_valid),
    .ret_pulse  (ret_pulse),
    .busy       (busy),
    .multi_err  (multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         t;
    logic [1:0] eo;
    logic       ret;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  // Expected strobe: edge 0 is the first posedge after btn changes at this negedge.
  function automatic void push(logic [1:0] eo, logic ret);
    exp_t e;
    e.t   = edge_n + 1 + LAT;
    e.eo  = eo;
    e.ret = ret;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (coin_valid || ret_pulse) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", {EO, coin_valid, ret_pulse}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("strobe_edge", edge_n, e.t);
          chk("strobe_eo", EO, e.eo);
          chk("strobe_coin_valid", coin_valid, (e.eo != 2'b00));
          chk("strobe_ret", ret_pulse, e.ret);
        end
      end else begin
        chk("quiet_eo", EO, 0);
      end
    end
  end

  initial begin
    int m;
    reset = 1'b1;
    btn   = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_eo", EO, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_ret", ret_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_multi_err", multi_err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single nickel held 20 cycles
    btn = 4'b0001;
    push(2'b01, 1'b0);
    repeat (LAT + 5) @(negedge clk);
    chk("nickel_busy_held", busy, 1);
    repeat (20 - (LAT + 5)) @(negedge clk);
    btn = 4'b0000;
    repeat (LAT) @(negedge clk);
    chk("nickel_busy_before_release", busy, 1);
    @(negedge clk);
    chk("nickel_idle_after_release", busy, 0);
    repeat (5) @(negedge clk);

    // glitch one sample short of the debounce window
    btn = 4'b0100;
    repeat (D - 1) @(negedge clk);
    btn = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("glitch_idle", busy, 0);
    end

    // simultaneous nickel+dime+quarter
    chk("multi_err_clear", multi_err, 0);
    btn = 4'b0111;
    push(2'b11, 1'b0);
    repeat (LAT + 3) @(negedge clk);
    chk("multi_err_set", multi_err, 1);
    btn = 4'b0000;
    repeat (LAT + 2) @(negedge clk);
    chk("multi_idle", busy, 0);

    // return, then dime pressed while return held
    btn = 4'b1000;
    push(2'b00, 1'b1);
    repeat (LAT + 4) @(negedge clk);
    btn = 4'b1010;
    repeat (LAT + 4) @(negedge clk);
    chk("ret_lockout_busy", busy, 1);
    btn = 4'b0010;
    repeat (LAT + 4) @(negedge clk);
    chk("dime_held_busy", busy, 1);
    btn = 4'b0000;
    repeat (LAT + 2) @(negedge clk);
    chk("ret_idle", busy, 0);
    repeat (LAT + 4) @(negedge clk);
    chk("no_late_dime", busy, 0);
    chk("multi_err_sticky", multi_err, 1);

    // reset asserted during ISSUE
    btn = 4'b0001;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("pre_reset_coin_valid", coin_valid, 1);
    chk("pre_reset_eo", EO, 1);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_eo", EO, 0);
    chk("mid_reset_coin_valid", coin_valid, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_multi_err", multi_err, 0);
    btn = 4'b0010;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    push(2'b10, 1'b0);
    m = edge_n;
    repeat (LAT) @(negedge clk);
    chk("post_reset_not_yet_busy", busy, 0);
    repeat (20 - LAT) @(negedge clk);
    chk("post_reset_busy", busy, 1);
    btn = 4'b0000;
    repeat (LAT + 2) @(negedge clk);
    chk("post_reset_idle", busy, 0);
    chk("post_reset_multi_err", multi_err, 0);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    if (m < 0) $display("edge bookkeeping negative");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
